// File: rtl/axi_txn_sequencer_if.sv
// Command and transaction handshake bundle between the command source,
// the transaction sequencer and the downstream AXI4 burst master.
interface axi_txn_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic       txn_start;
  logic [1:0] txn_type;
  logic       txn_done;

  // Sequencer side: accepts commands, issues transactions.
  modport slave (
    input  cmd_valid,
    input  cmd_type,
    input  txn_done,
    output cmd_ready,
    output txn_start,
    output txn_type
  );

  // Environment side: command producer plus burst master.
  modport master (
    output cmd_valid,
    output cmd_type,
    output txn_done,
    input  cmd_ready,
    input  txn_start,
    input  txn_type
  );
endinterface

// File: rtl/axi_txn_sequencer.sv
// Command queue front end for the AXI4 burst master. Buffers write/read
// requests, replays them one at a time as a txn_start pulse train, waits for
// the master's done edge (or a timeout) and keeps saturating statistics.
module axi_txn_sequencer #(
  parameter int CMD_DEPTH    = 4,
  parameter int START_CYCLES = 5,
  parameter int GAP_CYCLES   = 2,
  parameter int TIMEOUT      = 1023,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  axi_txn_sequencer_if.slave           bus,
  output logic                         busy,
  output logic [$clog2(CMD_DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]         wr_count,
  output logic [CNT_WIDTH-1:0]         rd_count,
  output logic [CNT_WIDTH-1:0]         err_count,
  output logic                         timeout_flag
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [LW-1:0] DEPTH_L    = LW'(CMD_DEPTH);
  localparam logic [LW-1:0] LVL_ONE    = LW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [SW-1:0] START_LAST = SW'(START_CYCLES - 1);
  localparam logic [SW-1:0] START_ONE  = SW'(1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GW-1:0] GAP_ONE    = GW'(1);
  // Timeout counter holds "cycles elapsed minus one", so it fires on the
  // cycle that completes TIMEOUT cycles since the first start cycle.
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE    = TW'(1);
  localparam bit            GAP_SKIP   = (GAP_CYCLES == 0);

  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_WR   = 2'b01;
  localparam logic [1:0] TYPE_RD   = 2'b10;
  localparam logic [1:0] TYPE_RSV  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_next_s;

  logic [1:0]      mem_r [CMD_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [LW-1:0]   level_r;
  logic [LW-1:0]   level_next_s;
  logic            cmd_ready_r;

  logic            txn_start_r;
  logic [1:0]      txn_type_r;
  logic            txn_done_q_r;
  logic            done_seen_r;
  logic [SW-1:0]   start_cnt_r;
  logic [GW-1:0]   gap_cnt_r;
  logic [TW-1:0]   tmo_cnt_r;

  logic [CNT_WIDTH-1:0] wr_count_r;
  logic [CNT_WIDTH-1:0] rd_count_r;
  logic [CNT_WIDTH-1:0] err_count_r;
  logic                 timeout_flag_r;

  logic            accept_s;
  logic            push_s;
  logic            reject_s;
  logic            pop_s;
  logic            done_edge_s;
  logic            complete_s;
  logic            timeout_s;
  logic [1:0]      err_inc_s;

  // Saturating add of a small increment onto a statistics counter.
  function automatic logic [CNT_WIDTH-1:0] sat_add(
    input logic [CNT_WIDTH-1:0] cnt,
    input logic [1:0]           inc
  );
    logic [CNT_WIDTH+1:0] sum;
    sum = {2'b00, cnt} + {{CNT_WIDTH{1'b0}}, inc};
    if (sum[CNT_WIDTH+1:CNT_WIDTH] != 2'b00) begin
      sat_add = {CNT_WIDTH{1'b1}};
    end else begin
      sat_add = sum[CNT_WIDTH-1:0];
    end
  endfunction

  assign accept_s    = bus.cmd_valid && cmd_ready_r;
  assign push_s      = accept_s && ((bus.cmd_type == TYPE_WR) || (bus.cmd_type == TYPE_RD));
  assign reject_s    = accept_s && (bus.cmd_type == TYPE_RSV);
  assign pop_s       = (state_r == ST_IDLE) && (level_r != {LW{1'b0}});
  assign done_edge_s = bus.txn_done && !txn_done_q_r;
  assign err_inc_s   = {1'b0, reject_s} + {1'b0, timeout_s};

  // Next FIFO occupancy from this cycle's push/pop pair.
  always_comb begin
    level_next_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_next_s = level_r + LVL_ONE;
      2'b01:   level_next_s = level_r - LVL_ONE;
      default: level_next_s = level_r;
    endcase
  end

  // Sequencer next-state logic and completion/timeout strobes.
  always_comb begin
    state_next_s = state_r;
    complete_s   = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (start_cnt_r == START_LAST) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_WAIT: begin
        // A done edge seen during START was latched; it completes here once.
        if (done_edge_s || done_seen_r) begin
          complete_s   = 1'b1;
          state_next_s = GAP_SKIP ? ST_IDLE : ST_GAP;
        end else if (tmo_cnt_r == TMO_LAST) begin
          timeout_s    = 1'b1;
          state_next_s = GAP_SKIP ? ST_IDLE : ST_GAP;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_GAP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Command FIFO pointers, occupancy and registered ready; payload is not reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      level_r     <= {LW{1'b0}};
      cmd_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= bus.cmd_type;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r     <= level_next_s;
      cmd_ready_r <= (level_next_s < DEPTH_L);
    end
  end

  // Per-transaction control: start pulse, type, done-edge latch and timers.
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_start_r  <= 1'b0;
      txn_type_r   <= TYPE_NONE;
      txn_done_q_r <= 1'b0;
      done_seen_r  <= 1'b0;
      start_cnt_r  <= {SW{1'b0}};
      gap_cnt_r    <= {GW{1'b0}};
      tmo_cnt_r    <= {TW{1'b0}};
    end else begin
      txn_start_r  <= (state_next_s == ST_START);
      txn_done_q_r <= bus.txn_done;

      if (pop_s) begin
        txn_type_r  <= mem_r[rd_ptr_r];
        done_seen_r <= 1'b0;
        start_cnt_r <= {SW{1'b0}};
        tmo_cnt_r   <= {TW{1'b0}};
      end else begin
        if ((state_r == ST_START) && done_edge_s) begin
          done_seen_r <= 1'b1;
        end
        if (state_r == ST_START) begin
          start_cnt_r <= start_cnt_r + START_ONE;
        end
        if (((state_r == ST_START) || (state_r == ST_WAIT)) && (tmo_cnt_r != TMO_LAST)) begin
          tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end
      end

      if (state_r == ST_GAP) begin
        gap_cnt_r <= gap_cnt_r + GAP_ONE;
      end else begin
        gap_cnt_r <= {GW{1'b0}};
      end
    end
  end

  // Saturating completion/error statistics and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_r     <= {CNT_WIDTH{1'b0}};
      rd_count_r     <= {CNT_WIDTH{1'b0}};
      err_count_r    <= {CNT_WIDTH{1'b0}};
      timeout_flag_r <= 1'b0;
    end else begin
      if (complete_s && (txn_type_r == TYPE_WR)) begin
        wr_count_r <= sat_add(wr_count_r, 2'b01);
      end
      if (complete_s && (txn_type_r == TYPE_RD)) begin
        rd_count_r <= sat_add(rd_count_r, 2'b01);
      end
      err_count_r <= sat_add(err_count_r, err_inc_s);
      if (timeout_s) begin
        timeout_flag_r <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.txn_start = txn_start_r;
  assign bus.txn_type  = txn_type_r;
  assign busy          = (state_r != ST_IDLE) || (level_r != {LW{1'b0}});
  assign fifo_level    = level_r;
  assign wr_count      = wr_count_r;
  assign rd_count      = rd_count_r;
  assign err_count     = err_count_r;
  assign timeout_flag  = timeout_flag_r;

endmodule
